// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, row sync, per-frame key resolve,
// frame-level debounce and registered decode for the 24-game FSM.
//
// Debounce states:
//   state      | meaning
//   DB_PENDING | candidate seen fewer than DEBOUNCE_SCANS frames in a row
//   DB_SETTLED | candidate confirmed; stable key equals candidate
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] decode,
    output logic       start,
    output logic       restart,
    output logic       key_valid
);

    localparam int         DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [4:0] KEY_NONE = 5'd16;
    localparam logic [3:0] DB_N     = 4'(DEBOUNCE_SCANS);

    typedef enum logic {DB_PENDING, DB_SETTLED} db_state_t;

    // Key id is {row, col}; NONE sits outside the 0..15 range.
    function automatic logic [3:0] key_code(input logic [4:0] id);
        case (id)
            5'd0:    key_code = 4'd1;
            5'd1:    key_code = 4'd2;
            5'd2:    key_code = 4'd3;
            5'd3:    key_code = 4'd10;
            5'd4:    key_code = 4'd4;
            5'd7:    key_code = 4'd11;
            5'd11:   key_code = 4'd12;
            5'd15:   key_code = 4'd13;
            default: key_code = 4'd0;
        endcase
    endfunction

    function automatic logic is_mapped(input logic [4:0] id);
        is_mapped = (key_code(id) != 4'd0) || (id == 5'd12) || (id == 5'd14);
    endfunction

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          last_dwell, frame_end;

    logic [3:0]    acc_id;
    logic [1:0]    acc_cnt;
    logic [2:0]    col_cnt, sum_cnt;
    logic [1:0]    col_row, next_cnt;
    logic [3:0]    next_id;
    logic [4:0]    frame_key;

    db_state_t     db_state;
    logic [4:0]    cand, stable;
    logic [3:0]    match;
    logic [3:0]    match_inc;

    assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
    assign frame_end  = last_dwell && (col_idx == 2'd3);
    assign match_inc  = match + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            col     <= 4'b1110;
        end else if (last_dwell) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= ~(4'b0001 << (col_idx + 2'd1));
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Fold this column's sample into the running frame result.
    always_comb begin
        col_cnt = 3'd0;
        col_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                col_cnt = col_cnt + 3'd1;
                col_row = 2'(r);
            end
        end
        sum_cnt   = {1'b0, acc_cnt} + col_cnt;
        next_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        next_id   = (col_cnt != 3'd0) ? {col_row, col_idx} : acc_id;
        frame_key = ((next_cnt == 2'd1) && is_mapped({1'b0, next_id})) ? {1'b0, next_id} : KEY_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_id  <= 4'd0;
            acc_cnt <= 2'd0;
        end else if (last_dwell) begin
            if (col_idx == 2'd3) begin
                acc_id  <= 4'd0;
                acc_cnt <= 2'd0;
            end else begin
                acc_id  <= next_id;
                acc_cnt <= next_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_state  <= DB_PENDING;
            cand      <= KEY_NONE;
            stable    <= KEY_NONE;
            match     <= 4'd0;
            decode    <= 4'd0;
            start     <= 1'b0;
            restart   <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            decode    <= key_code(stable);
            start     <= (stable == 5'd12);
            restart   <= (stable == 5'd14);
            key_valid <= is_mapped(stable);
            if (frame_end) begin
                if (frame_key != cand) begin
                    cand  <= frame_key;
                    match <= 4'd1;
                    if (DB_N == 4'd1) begin
                        stable   <= frame_key;
                        db_state <= DB_SETTLED;
                    end else begin
                        db_state <= DB_PENDING;
                    end
                end else if (db_state == DB_PENDING) begin
                    match <= match_inc;
                    if (match_inc == DB_N) begin
                        stable   <= cand;
                        db_state <= DB_SETTLED;
                    end
                end
            end
        end
    end

endmodule
